// File: rtl/blinker_pkg.sv
// Shared constants and elaboration helpers for the blinker square-wave generator.
package blinker_pkg;

    localparam int C_OUT_W = 12;

    // Half-period in clock cycles; 64-bit so 100 MHz x long periods cannot overflow.
    function automatic longint unsigned half_cycles(input longint unsigned clkFrq,
                                                    input longint unsigned periodMs);
        return (clkFrq * periodMs) / 64'd2000;
    endfunction

    function automatic int cnt_width(input longint unsigned half);
        int w;
        w = $clog2(half);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/blinker_tick.sv
// Half-period counter: emits a one-cycle tick on the last cycle of every C_HALF-cycle span.
module blinker_tick
    import blinker_pkg::*;
#(
    parameter longint unsigned C_HALF = 1
) (
    input  logic clk,
    input  logic rstb,
    output logic tick
);

    localparam int                 C_CNT_W = cnt_width(C_HALF);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(C_HALF - 64'd1);

    logic [C_CNT_W-1:0] rCnt;

    assign tick = (rCnt == C_LAST);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            rCnt <= '0;
        end else if (tick) begin
            rCnt <= '0;
        end else begin
            rCnt <= rCnt + 1'b1;
        end
    end

endmodule

// File: rtl/blinker.sv
// 50% duty-cycle blink of C_PERIOD ms, replicated onto the 12-bit lamp bus.
module blinker
    import blinker_pkg::*;
#(
    parameter int C_CLK_FRQ = 100000000,
    parameter int C_PERIOD  = 1
) (
    input  logic               clk,
    input  logic               rstb,
    output logic [C_OUT_W-1:0] out
);

    localparam longint unsigned C_HALF = half_cycles(64'(C_CLK_FRQ), 64'(C_PERIOD));

    generate
        if (C_HALF < 64'd1) begin : gBadHalf
            $error("blinker: C_CLK_FRQ * C_PERIOD too small, half-period rounds to zero cycles");
        end
    endgenerate

    logic tick;
    logic rWave;

    blinker_tick #(
        .C_HALF(C_HALF)
    ) uTick (
        .clk (clk),
        .rstb(rstb),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            rWave <= 1'b0;
        end else if (tick) begin
            rWave <= ~rWave;
        end
    end

    // Driven only from the wave register, so no input reaches the lamps combinationally.
    assign out = {C_OUT_W{rWave}};

endmodule

// File: tb/tb_blinker.sv
// Directed bench for blinker: C_HALF=2 vector table, C_HALF=1 boundary, and a jittered-clock period run.
module tb_blinker;

    typedef struct {
        logic        rstb;
        logic [11:0] expOut;
    } vec_t;

    logic        clk    = 1'b0;
    logic        clkJ   = 1'b0;
    logic        rstbA  = 1'b0;
    logic        rstbB  = 1'b0;
    logic        rstbC  = 1'b0;
    logic [11:0] outA;
    logic [11:0] outB;
    logic [11:0] outC;

    int passCnt  = 0;
    int totalCnt = 0;
    int badBits  = 0;

    vec_t vecs[$];

    // C_HALF = 2
    blinker #(.C_CLK_FRQ(2000), .C_PERIOD(2)) uDutA (.clk(clk), .rstb(rstbA), .out(outA));
    // C_HALF = 1
    blinker #(.C_CLK_FRQ(2000), .C_PERIOD(1)) uDutB (.clk(clk), .rstb(rstbB), .out(outB));
    // C_HALF = 300003/2000 = 150 (truncated)
    blinker #(.C_CLK_FRQ(100001), .C_PERIOD(3)) uDutC (.clk(clkJ), .rstb(rstbC), .out(outC));

    always #5000 clk = ~clk;

    always begin
        #(5000 + $urandom_range(100) - 50);
        clkJ = ~clkJ;
    end

    always @(negedge clkJ) begin
        if (outC !== 12'h000 && outC !== 12'hFFF) badBits++;
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    initial begin
        int n;
        logic [11:0] level;

        // Reset hold, 20 clocks
        for (int i = 0; i < 20; i++) vecs.push_back('{1'b0, 12'h000});
        // Release: edges 1..8
        vecs.push_back('{1'b1, 12'h000});
        vecs.push_back('{1'b1, 12'hFFF});
        vecs.push_back('{1'b1, 12'hFFF});
        vecs.push_back('{1'b1, 12'h000});
        vecs.push_back('{1'b1, 12'h000});
        vecs.push_back('{1'b1, 12'hFFF});
        vecs.push_back('{1'b1, 12'hFFF});
        vecs.push_back('{1'b1, 12'h000});
        // Edges 9,10 then reset while high with counter at 0
        vecs.push_back('{1'b1, 12'h000});
        vecs.push_back('{1'b1, 12'hFFF});
        vecs.push_back('{1'b0, 12'h000});
        vecs.push_back('{1'b1, 12'h000});
        vecs.push_back('{1'b1, 12'hFFF});
        vecs.push_back('{1'b1, 12'hFFF});
        // Reset while high with counter at 1
        vecs.push_back('{1'b0, 12'h000});
        vecs.push_back('{1'b1, 12'h000});
        vecs.push_back('{1'b1, 12'hFFF});
        vecs.push_back('{1'b1, 12'hFFF});
        vecs.push_back('{1'b1, 12'h000});

        foreach (vecs[i]) begin
            @(negedge clk);
            rstbA = vecs[i].rstb;
            @(posedge clk);
            #1;
            check($sformatf("halfTwo[%0d]", i), outA, vecs[i].expOut);
        end

        // C_HALF = 1: toggles every clock, first high after edge 1
        @(negedge clk);
        check("halfOneReset", outB, 12'h000);
        rstbB = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("halfOneEdge%0d", i), outB, (i % 2 == 1) ? 12'hFFF : 12'h000);
        end

        // Jittered clock, C_HALF = 150: first rise, then 3 full periods
        @(negedge clkJ);
        check("longReset", outC, 12'h000);
        @(negedge clkJ);
        rstbC = 1'b1;
        n = 0;
        do begin
            @(posedge clkJ);
            #1;
            n++;
        end while (outC !== 12'hFFF && n < 1000);
        checkInt("longFirstRise", n, 150);

        for (int p = 0; p < 6; p++) begin
            level = outC;
            n = 0;
            do begin
                @(posedge clkJ);
                #1;
                n++;
            end while (outC === level && n < 1000);
            checkInt($sformatf("longPhase%0d_%s", p, (p % 2 == 0) ? "high" : "low"), n, 150);
        end
        checkInt("longBitsIdentical", badBits, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
